// File: rtl/cpu_core_param_if.sv
// Instruction-memory fetch channel: the core requests a word at mem_addr and the
// memory answers with mem_ack/mem_rdata after any number of wait cycles.
interface cpu_core_param_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/cpu_core_param.sv
// Parametrised model CPU: FSM-sequenced fetch/execute over a generic register file,
// with Z/C flags, immediate loads, conditional jumps and a resumable HALT.
module cpu_core_param #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned RSEL_W = 2
) (
   input  logic                              clk,
   input  logic                              CLEARn,
   input  logic                              RUN,
   cpu_core_param_if.master                  mem,
   output logic [ADDR_W-1:0]                 pc,
   output logic [DATA_W-1:0]                 ir,
   output logic                              flag_z,
   output logic                              flag_c,
   output logic                              halt,
   output logic [(2**RSEL_W)*DATA_W-1:0]     regs_dbg
);
   localparam int unsigned NREG = 2**RSEL_W;

   typedef enum logic [2:0] {StIdle, StFetch, StExec, StImm, StHalted} state_e;

   state_e              r_state;
   state_e              w_state_d;
   logic [ADDR_W-1:0]   r_pc;
   logic [DATA_W-1:0]   r_ir;
   logic [DATA_W-1:0]   r_regs [NREG];
   logic                r_z;
   logic                r_c;
   logic                r_run_q;

   logic [3:0]          w_op;
   logic [RSEL_W-1:0]   w_dst;
   logic [RSEL_W-1:0]   w_src;
   logic [DATA_W-1:0]   w_a;
   logic [DATA_W-1:0]   w_b;
   logic [DATA_W:0]     w_sum;
   logic [2*DATA_W-1:0] w_prod;
   logic [DATA_W-1:0]   w_res;
   logic                w_cy;
   logic                w_wr;
   logic                w_flg;
   logic                w_req;
   logic                w_ack;
   logic [ADDR_W-1:0]   w_pc_inc;
   logic [ADDR_W-1:0]   w_imm;

   assign w_op     = r_ir[DATA_W-1 -: 4];
   assign w_dst    = r_ir[2*RSEL_W-1:RSEL_W];
   assign w_src    = r_ir[RSEL_W-1:0];
   assign w_a      = r_regs[w_dst];
   assign w_b      = r_regs[w_src];
   assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
   assign w_prod   = {{DATA_W{1'b0}}, w_a} * {{DATA_W{1'b0}}, w_b};
   assign w_pc_inc = r_pc + ADDR_W'(1);
   assign w_imm    = mem.mem_rdata[ADDR_W-1:0];

   // Request is decoded straight from state so an async reset drops it at once.
   assign w_req        = (r_state == StFetch) || (r_state == StImm);
   assign w_ack        = w_req & mem.mem_ack;
   assign mem.mem_req  = w_req;
   assign mem.mem_addr = r_pc;

   always_comb begin
      w_res = w_a;
      w_cy  = 1'b0;
      w_wr  = 1'b0;
      w_flg = 1'b0;
      case (w_op)
         4'h1: begin w_res = w_b; w_wr = 1'b1; end
         4'h2: begin w_res = w_sum[DATA_W-1:0]; w_cy = w_sum[DATA_W]; w_wr = 1'b1; w_flg = 1'b1; end
         4'h3: begin w_res = w_a - w_b; w_cy = (w_a < w_b); w_wr = 1'b1; w_flg = 1'b1; end
         4'h4: begin w_res = w_a & w_b; w_wr = 1'b1; w_flg = 1'b1; end
         4'h5: begin w_res = w_a | w_b; w_wr = 1'b1; w_flg = 1'b1; end
         4'h6: begin w_res = w_a ^ w_b; w_wr = 1'b1; w_flg = 1'b1; end
         4'h7: begin w_res = ~w_b; w_wr = 1'b1; w_flg = 1'b1; end
         4'h8: begin
            w_res = {w_b[DATA_W-2:0], 1'b0}; w_cy = w_b[DATA_W-1]; w_wr = 1'b1; w_flg = 1'b1;
         end
         4'h9: begin
            w_res = {1'b0, w_b[DATA_W-1:1]}; w_cy = w_b[0]; w_wr = 1'b1; w_flg = 1'b1;
         end
         4'hA: begin
            w_res = w_prod[DATA_W-1:0]; w_cy = |w_prod[2*DATA_W-1:DATA_W];
            w_wr  = 1'b1; w_flg = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle:   if (RUN) w_state_d = StFetch;
         StFetch:  if (w_ack) w_state_d = StExec;
         StExec: begin
            case (w_op)
               4'hB, 4'hC, 4'hD, 4'hE: w_state_d = StImm;
               4'hF:                   w_state_d = StHalted;
               default:                w_state_d = StFetch;
            endcase
         end
         StImm:    if (w_ack) w_state_d = StFetch;
         // Resume needs a fresh rising edge, so a RUN held high through HALT is ignored.
         StHalted: if (RUN && !r_run_q) w_state_d = StFetch;
         default:  w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge CLEARn) begin
      if (!CLEARn) begin
         r_state <= StIdle;
         r_pc    <= '0;
         r_ir    <= '0;
         r_z     <= 1'b0;
         r_c     <= 1'b0;
         r_run_q <= 1'b0;
         for (int unsigned k = 0; k < NREG; k++) r_regs[k] <= '0;
      end else begin
         r_state <= w_state_d;
         r_run_q <= RUN;
         if (r_state == StFetch && w_ack) begin
            r_ir <= mem.mem_rdata;
            r_pc <= w_pc_inc;
         end
         if (r_state == StExec) begin
            if (w_wr) r_regs[w_dst] <= w_res;
            if (w_flg) begin
               r_z <= (w_res == '0);
               r_c <= w_cy;
            end
         end
         if (r_state == StImm && w_ack) begin
            case (w_op)
               4'hB: begin
                  r_regs[w_dst] <= mem.mem_rdata;
                  r_pc          <= w_pc_inc;
               end
               4'hC:    r_pc <= w_imm;
               4'hD:    r_pc <= r_z ? w_imm : w_pc_inc;
               4'hE:    r_pc <= r_c ? w_imm : w_pc_inc;
               default: r_pc <= w_pc_inc;
            endcase
         end
      end
   end

   assign pc     = r_pc;
   assign ir     = r_ir;
   assign flag_z = r_z;
   assign flag_c = r_c;
   assign halt   = (r_state == StHalted);

   for (genvar k = 0; k < NREG; k++) begin : g_dbg
      assign regs_dbg[k*DATA_W +: DATA_W] = r_regs[k];
   end
endmodule

// File: doc/cpu_core_param.md
Name: cpu_core_param

Overview:
- Parametrised successor to the fixed 8-bit model CPU.
- A single FSM replaces the one-hot beat generator. Register file width and depth are generic.
- Instruction memory is external, behind a req/ack handshake with variable latency.
- Adds Z/C flags, an immediate load, conditional jumps, and a resumable HALT. Sits at the CPU top level, between the program ROM and the debug/display logic.

Parameters:
- DATA_W, 8, datapath and instruction word width; must be ≥ 4+2*RSEL_W and ≥ ADDR_W.
- ADDR_W, 8, program counter and memory address width.
- RSEL_W, 2, register-select field width; NREG = 2**RSEL_W general registers.

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- CLEARn, in, 1, asynchronous active-low reset.
- RUN, in, 1, start/resume request; level-sampled in IDLE, rising-edge-sampled in HALTED.
- mem_req, out, 1, fetch request to instruction memory.
- mem_addr, out, ADDR_W, fetch address; valid while mem_req=1.
- mem_ack, in, 1, memory word valid this cycle; ignored when mem_req=0.
- mem_rdata, in, DATA_W, fetched word; captured when mem_req & mem_ack.
- pc, out, ADDR_W, program counter.
- ir, out, DATA_W, instruction register.
- flag_z, out, 1, zero flag.
- flag_c, out, 1, carry/borrow flag.
- halt, out, 1, high in HALTED state.
- regs_dbg, out, NREG*DATA_W, register file flattened; reg k at bits [k*DATA_W +: DATA_W].

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, pc=0, ir=0, all regs=0, flags=0, mem_req=0, halt=0.
- Instruction word: op=ir[DATA_W-1 -: 4], dst=ir[2*RSEL_W-1:RSEL_W], src=ir[RSEL_W-1:0]; any bits between the fields are ignored.
- Opcodes:
  - 0 NOP.
  - 1 MOV dst=src.
  - 2 ADD dst=dst+src.
  - 3 SUB dst=dst-src.
  - 4 AND, 5 OR, 6 XOR (dst op src).
  - 7 NOT dst=~src.
  - 8 SHL dst=src<<1.
  - 9 SHR dst=src>>1 (logical).
  - A MUL dst=low DATA_W bits of dst*src.
  - B LDI dst=next word.
  - C JMP, D JZ, E JC, each to the next word's low ADDR_W bits.
  - F HALT.
- States:
  - IDLE: RUN=1 → FETCH.
  - FETCH: mem_req=1, mem_addr=pc. On ack: ir<=mem_rdata, pc<=pc+1, → EXEC. With no ack, stay; mem_addr and mem_req are held stable.
  - EXEC, one cycle:
    - ALU ops and MOV/NOP: write result, → FETCH.
    - B/C/D/E: → IMM.
    - F: → HALTED.
  - IMM: mem_req=1, mem_addr=pc. On ack:
    - LDI: reg[dst]<=mem_rdata, pc<=pc+1.
    - JMP: pc<=imm.
    - JZ: pc<=flag_z ? imm : pc+1.
    - JC: pc<=flag_c ? imm : pc+1.
    - Then → FETCH.
  - HALTED: halt=1, pc already points past the HALT. A 0→1 edge of RUN (registered run_q) → FETCH. RUN already high on entry does not resume; it must be dropped first.
- Timing:
  - ALU instruction: 2 cycles with zero-wait memory.
  - Immediate/jump instruction: 3 cycles with zero-wait memory.
  - Each memory wait cycle adds one cycle.
- Flags, written only by ADD, SUB, AND, OR, XOR, NOT, SHL, SHR, MUL:
  - Z = (result==0).
  - ADD: C = carry-out.
  - SUB: C = borrow (dst<src).
  - SHL: C = src[MSB]. SHR: C = src[0].
  - MUL: C = |high half of product.
  - Logic ops: C=0.
  - MOV, LDI, NOP, jumps and HALT leave both flags unchanged.
- Register rules: the register write and the flag update happen on the same edge. dst==src is legal; operands are read before the write.
- PC wraps modulo 2**ADDR_W, both on increment and on fetch at the top address.
- Reset mid-transaction: mem_req drops asynchronously and the pending ack is discarded. After CLEARn deasserts, the core restarts from IDLE at pc=0.
- mem_ack arriving while mem_req=0 has no effect.

Test Plan:
- Zero-wait program (8-bit defaults): B4 7F, B8 01, 26, F0.
  - Required: R1=0x80, R2=0x01, Z=0, C=0, halt=1, pc=0x06.
  - Cycle count from RUN to halt: 10.
- Carry/zero: LDI R1,FF; LDI R2,01; ADD R1,R2; JC 0x20.
  - Required: R1=0x00, Z=1, C=1, next fetch address 0x20.
  - With C=0 instead, the next fetch is at pc+1.
- Wait states: ack delayed 3 cycles on every fetch.
  - mem_addr and mem_req stay stable for all wait cycles.
  - Register results are identical to the zero-wait run.
  - Each instruction is 3 cycles longer per memory word.
- HALT/resume: RUN held high through HALT.
  - The core stays halted.
  - RUN 1→0→1 resumes at the address after HALT, and halt drops the next cycle.
- Reset mid-FETCH: assert CLEARn=0 while mem_req=1 and ack is pending.
  - mem_req drops immediately; all regs=0, pc=0.
  - After release with RUN=1, the first fetch is at address 0x00.
- PC wrap and MUL: JMP FF with NOP at 0xFF; then LDI R1,10; LDI R2,20; MUL R1,R2.
  - Fetch after 0xFF is at 0x00.
  - MUL 0x10*0x20 gives R1=0x00, Z=1, C=1.
